// File: rtl/lpif_link_online_seq.sv
// Link bring-up sequencer: waits for all PHY channels to align, settles, then raises
// tx_online and later rx_online; on PHY loss tears down and retries with backoff.
module lpif_link_online_seq #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int MAX_RETRY      = 3,
  parameter int BACKOFF_CYCLES = 16
) (
  input  logic              clk_wr,
  input  logic              rst_wr,
  input  logic              link_en,
  input  logic [NUM_CH-1:0] phy_ready,
  input  logic [CNT_W-1:0]  settle_cycles,
  input  logic [CNT_W-1:0]  timeout_cycles,
  input  logic [CNT_W-1:0]  rx_delay_cycles,
  output logic              tx_online,
  output logic              rx_online,
  output logic              link_up,
  output logic              link_fault,
  output logic [1:0]        retry_cnt,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_PHY = 3'd1;
  localparam logic [2:0] ST_SETTLE   = 3'd2;
  localparam logic [2:0] ST_TX_ON    = 3'd3;
  localparam logic [2:0] ST_ACTIVE   = 3'd4;
  localparam logic [2:0] ST_BACKOFF  = 3'd5;
  localparam logic [2:0] ST_FAULT    = 3'd6;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       retry_reg, retry_next;
  logic             bo_fault_reg, bo_fault_next;
  logic             tx_reg, rx_reg, up_reg, fault_reg;
  logic             ready_all;
  logic [CNT_W-1:0] timeout_last;
  logic             entering;

  assign ready_all    = &phy_ready;
  assign timeout_last = timeout_cycles - CNT_W'(1);
  assign entering     = (state_next != state_reg);

  always_comb begin
    state_next = state_reg;
    if (!link_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:     state_next = ST_WAIT_PHY;
        ST_WAIT_PHY: begin
          if (ready_all)
            state_next = ST_SETTLE;
          else if (timeout_cycles != '0 && cnt_reg == timeout_last)
            state_next = ST_BACKOFF;
        end
        ST_SETTLE: begin
          if (!ready_all)
            state_next = ST_WAIT_PHY;
          else if (cnt_reg >= settle_cycles)
            state_next = ST_TX_ON;
        end
        ST_TX_ON: begin
          if (!ready_all)
            state_next = ST_BACKOFF;
          else if (cnt_reg >= rx_delay_cycles)
            state_next = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!ready_all)
            state_next = ST_BACKOFF;
        end
        ST_BACKOFF: begin
          // bo_fault_reg records that retries were already exhausted at entry
          if (bo_fault_reg)
            state_next = ST_FAULT;
          else if (cnt_reg == BACKOFF_LAST)
            state_next = ST_WAIT_PHY;
        end
        ST_FAULT:    state_next = ST_FAULT;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_next      = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_W'(1);
    retry_next    = retry_reg;
    bo_fault_next = bo_fault_reg;
    if (entering)
      cnt_next = '0;
    if (state_next == ST_IDLE || (entering && state_next == ST_ACTIVE)) begin
      retry_next = 2'd0;
    end else if (entering && state_next == ST_BACKOFF) begin
      if (retry_reg == RETRY_LIMIT) begin
        bo_fault_next = 1'b1;
      end else begin
        bo_fault_next = 1'b0;
        retry_next    = retry_reg + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      retry_reg    <= 2'd0;
      bo_fault_reg <= 1'b0;
      tx_reg       <= 1'b0;
      rx_reg       <= 1'b0;
      up_reg       <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      retry_reg    <= retry_next;
      bo_fault_reg <= bo_fault_next;
      tx_reg       <= (state_next == ST_TX_ON) || (state_next == ST_ACTIVE);
      rx_reg       <= (state_next == ST_ACTIVE);
      up_reg       <= (state_next == ST_ACTIVE);
      fault_reg    <= (state_next == ST_FAULT);
    end
  end

  assign tx_online  = tx_reg;
  assign rx_online  = rx_reg;
  assign link_up    = up_reg;
  assign link_fault = fault_reg;
  assign retry_cnt  = retry_reg;
  assign state_dbg  = state_reg;

endmodule

// File: tb/tb_lpif_link_online_seq.sv
// Self-checking bench for lpif_link_online_seq: vector table, hand-written corner
// sequences and a randomized run compared against a rule-level reference model.
module tb_lpif_link_online_seq;

  logic        clk_wr = 1'b0;
  logic        rst_wr = 1'b1;
  logic        link_en = 1'b0;
  logic [3:0]  phy_ready = 4'h0;
  logic [15:0] settle_cycles = 16'd4;
  logic [15:0] timeout_cycles = 16'd0;
  logic [15:0] rx_delay_cycles = 16'd3;
  logic        tx_online, rx_online, link_up, link_fault;
  logic [1:0]  retry_cnt;
  logic [2:0]  state_dbg;

  lpif_link_online_seq #(
    .NUM_CH(4), .CNT_W(16), .MAX_RETRY(3), .BACKOFF_CYCLES(16)
  ) dut (
    .clk_wr(clk_wr), .rst_wr(rst_wr), .link_en(link_en), .phy_ready(phy_ready),
    .settle_cycles(settle_cycles), .timeout_cycles(timeout_cycles),
    .rx_delay_cycles(rx_delay_cycles), .tx_online(tx_online), .rx_online(rx_online),
    .link_up(link_up), .link_fault(link_fault), .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  always #5 clk_wr = ~clk_wr;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: state named by its role, time-in-state as an unbounded integer.
  localparam int S_IDLE = 0, S_WAIT = 1, S_SETTLE = 2, S_TX = 3, S_ACTIVE = 4,
                 S_BACKOFF = 5, S_FAULT = 6;
  int m_st = S_IDLE, m_age = 0, m_retry = 0;
  bit m_exhausted = 1'b0;

  function automatic int m_dest(input bit en, input bit rdy);
    if (!en) return S_IDLE;
    if (m_st == S_IDLE) return S_WAIT;
    if (m_st == S_WAIT) begin
      if (rdy) return S_SETTLE;
      if (timeout_cycles != 0 && m_age + 1 == int'(timeout_cycles)) return S_BACKOFF;
      return S_WAIT;
    end
    if (m_st == S_SETTLE) return !rdy ? S_WAIT : (m_age >= int'(settle_cycles) ? S_TX : S_SETTLE);
    if (m_st == S_TX) return !rdy ? S_BACKOFF : (m_age >= int'(rx_delay_cycles) ? S_ACTIVE : S_TX);
    if (m_st == S_ACTIVE) return !rdy ? S_BACKOFF : S_ACTIVE;
    if (m_st == S_BACKOFF) return m_exhausted ? S_FAULT : (m_age + 1 == 16 ? S_WAIT : S_BACKOFF);
    return S_FAULT;
  endfunction

  task automatic model_step(input bit en, input bit rdy);
    int nxt;
    nxt = m_dest(en, rdy);
    if (nxt == S_IDLE) m_retry = 0;
    if (nxt != m_st) begin
      m_age = 0;
      if (nxt == S_ACTIVE) m_retry = 0;
      if (nxt == S_BACKOFF) begin
        m_exhausted = (m_retry == 3);
        if (!m_exhausted) m_retry++;
      end
    end else begin
      m_age++;
    end
    m_st = nxt;
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_age = 0; m_retry = 0; m_exhausted = 1'b0;
  endtask

  function automatic logic [7:0] pack(input int st, input bit tx, input bit rx, input bit up,
                                      input bit flt, input int rc);
    return {st[2:0], tx, rx, up, flt, rc[1:0]};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {state_dbg, tx_online, rx_online, link_up, link_fault, retry_cnt};
  endfunction

  function automatic logic [7:0] model_vec();
    return pack(m_st, m_st == S_TX || m_st == S_ACTIVE, m_st == S_ACTIVE, m_st == S_ACTIVE,
                m_st == S_FAULT, m_retry);
  endfunction

  // One clock: drive inputs, let the edge pass, sample 1 ns later and compare to the model.
  task automatic step(input bit en, input logic [3:0] rdy);
    link_en = en;
    phy_ready = rdy;
    @(posedge clk_wr);
    model_step(en, &rdy);
    #1;
    check("model", dut_vec(), model_vec());
  endtask

  task automatic steps(input int n, input bit en, input logic [3:0] rdy);
    for (int k = 0; k < n; k++) step(en, rdy);
  endtask

  typedef struct {
    bit         en;
    logic [3:0] rdy;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int n, input bit en, input logic [3:0] rdy, input logic [7:0] exp);
    vec_t v;
    v.en = en; v.rdy = rdy; v.exp = exp;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    // nominal bring-up (settle=4, rx_delay=3), then teardown from ACTIVE and from TX_ON
    add(1, 1, 4'hF, pack(S_WAIT, 0, 0, 0, 0, 0));
    add(5, 1, 4'hF, pack(S_SETTLE, 0, 0, 0, 0, 0));
    add(4, 1, 4'hF, pack(S_TX, 1, 0, 0, 0, 0));
    add(2, 1, 4'hF, pack(S_ACTIVE, 1, 1, 1, 0, 0));
    add(1, 0, 4'hF, pack(S_IDLE, 0, 0, 0, 0, 0));
    add(1, 1, 4'hF, pack(S_WAIT, 0, 0, 0, 0, 0));
    add(5, 1, 4'hF, pack(S_SETTLE, 0, 0, 0, 0, 0));
    add(1, 1, 4'hF, pack(S_TX, 1, 0, 0, 0, 0));
    add(2, 0, 4'hF, pack(S_IDLE, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk_wr);
    #1;
    check("reset_outputs", dut_vec(), 8'h00);
    @(negedge clk_wr);
    rst_wr = 1'b0;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, tbl[i].rdy);
      check($sformatf("tbl[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // glitch in SETTLE at cnt=2 restarts the whole window
    steps(4, 1, 4'hF);
    check("glitch_pre", state_dbg, 3'd2);
    step(1, 4'hE);
    check("glitch_wait", state_dbg, 3'd1);
    for (int k = 0; k < 5; k++) begin
      step(1, 4'hF);
      check("glitch_settle", {state_dbg, tx_online}, {3'd2, 1'b0});
    end
    step(1, 4'hF);
    check("glitch_txon", {state_dbg, tx_online}, {3'd3, 1'b1});
    step(0, 4'hF);

    // timeout, retry escalation and sticky fault
    timeout_cycles = 16'd10;
    step(1, 4'h7);
    steps(9, 1, 4'h7);
    check("timeout_edge", state_dbg, 3'd1);
    step(1, 4'h7);
    check("timeout_bo1", {state_dbg, retry_cnt}, {3'd5, 2'd1});
    for (int a = 2; a <= 4; a++) begin
      steps(15, 1, 4'h7);
      check("backoff_hold", state_dbg, 3'd5);
      step(1, 4'h7);
      check("backoff_exit", state_dbg, 3'd1);
      steps(10, 1, 4'h7);
      check("timeout_bo", {state_dbg, retry_cnt}, {3'd5, 2'(a > 3 ? 3 : a)});
    end
    step(1, 4'h7);
    check("fault_entry", {state_dbg, link_fault, retry_cnt}, {3'd6, 1'b1, 2'd3});
    steps(5, 1, 4'hF);
    check("fault_sticky", {state_dbg, link_fault}, {3'd6, 1'b1});
    step(0, 4'hF);
    check("fault_teardown", dut_vec(), 8'h00);
    timeout_cycles = 16'd0;

    // link loss in ACTIVE, then relink clears retry_cnt
    steps(11, 1, 4'hF);
    check("active", dut_vec(), pack(S_ACTIVE, 1, 1, 1, 0, 0));
    step(1, 4'hB);
    check("loss", dut_vec(), pack(S_BACKOFF, 0, 0, 0, 0, 1));
    steps(16, 1, 4'hF);
    check("relink_wait", {state_dbg, retry_cnt}, {3'd1, 2'd1});
    steps(10, 1, 4'hF);
    check("relink_active", dut_vec(), pack(S_ACTIVE, 1, 1, 1, 0, 0));

    // asynchronous reset between edges
    @(negedge clk_wr);
    rst_wr = 1'b1;
    #1;
    check("async_reset", dut_vec(), 8'h00);
    model_reset();
    @(negedge clk_wr);
    rst_wr = 1'b0;
    step(1, 4'hF);
    check("restart", state_dbg, 3'd1);

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        settle_cycles   = 16'($urandom_range(0, 6));
        rx_delay_cycles = 16'($urandom_range(0, 5));
        timeout_cycles  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
      end
      step($urandom_range(0, 39) != 0,
           ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
